// File: rtl/apb_slave_responder.sv
// APB completer with a small word register file, programmable wait states,
// decode-error responses and detection of master protocol violations.
module apb_slave_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [3:0]                cfg_wait,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic                      proto_err
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state;
    logic [3:0]            wcnt;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [2:0]            pprot_q;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  in_access;
    logic                  setup;
    logic                  bus_changed;
    logic                  viol;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]      idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  id_write;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_pprot;

    assign in_access = (state == ST_ACCESS);
    assign setup     = !in_access && psel && !penable;

    // Decode works only from the captured request, never from the live bus.
    assign word_addr    = paddr_q >> 2;
    assign idx          = word_addr[IDX_W-1:0];
    assign misaligned   = (paddr_q[1:0] != 2'b00);
    assign out_of_range = (word_addr >= ADDR_WIDTH'(NUM_REGS));
    assign id_write     = pwrite_q && (word_addr == '0);
    assign dec_err      = misaligned || out_of_range || id_write;

    assign bus_changed = (paddr != paddr_q) || (pwrite != pwrite_q) ||
                         (pwdata != pwdata_q) || (pstrb != pstrb_q);

    // Any deviation while a transfer is open, or penable outside a transfer.
    assign viol = in_access ? (!psel || bus_changed) : penable;

    assign pready  = in_access && psel && penable && (wcnt == 4'd0);
    assign pslverr = pready && dec_err;
    assign commit  = pready && pwrite_q && !dec_err && !viol;

    assign rd_word = (idx == '0) ? ID_VALUE : regs[idx];
    assign prdata  = (pready && !pwrite_q && !dec_err) ? rd_word : '0;

    // Protection attributes are held for completeness but have no effect.
    assign unused_pprot = ^pprot_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= viol;
            if (in_access) begin
                if (viol || pready) begin
                    state <= ST_IDLE;
                    wcnt  <= 4'd0;
                end else if (wcnt != 4'd0) begin
                    wcnt <= wcnt - 4'd1;
                end
            end else if (setup) begin
                state <= ST_ACCESS;
                wcnt  <= cfg_wait;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= 3'b000;
        end else if (setup) begin
            paddr_q  <= paddr;
            pwrite_q <= pwrite;
            pwdata_q <= pwdata;
            pstrb_q  <= pstrb;
            pprot_q  <= pprot;
        end
    end

    // Entry 0 is never written; reads of index 0 return ID_VALUE instead.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (pstrb_q[b]) begin
                    regs[idx][8*b +: 8] <= pwdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Randomized scoreboard bench for apb_slave_responder with a word-level register model.
module tb_apb_slave_responder;

    localparam int          NREGS = 16;
    localparam logic [31:0] ID    = 32'hA9B0_0001;

    logic        pclk     = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel     = 1'b0;
    logic        penable  = 1'b0;
    logic        pwrite   = 1'b0;
    logic [31:0] paddr    = '0;
    logic [31:0] pwdata   = '0;
    logic [3:0]  pstrb    = '0;
    logic [2:0]  pprot    = '0;
    logic [3:0]  cfg_wait = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          proto_exp  = 0;
    int          acc_cycles = 0;
    logic [31:0] model [NREGS];

    apb_slave_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (NREGS),
        .ID_VALUE  (ID)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pprot    (pprot),
        .cfg_wait (cfg_wait),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .proto_err(proto_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every completion is matched against the oldest expected response.
    always @(negedge pclk) begin
        if (!preset_n) begin
            acc_cycles = 0;
        end else begin
            if (pready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready actual=1 required=0 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("prdata", prdata, mon_e.rdata);
                    check("pslverr", {31'd0, pslverr}, {31'd0, mon_e.slverr});
                    check("wait_cycles", acc_cycles, mon_e.waits);
                end
                acc_cycles = 0;
            end else begin
                check("idle_prdata", prdata, 32'd0);
                check("idle_pslverr", {31'd0, pslverr}, 32'd0);
                if (psel && penable) acc_cycles++;
                else if (!psel) acc_cycles = 0;
            end
            if (proto_err) begin
                if (proto_exp == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_proto_err actual=1 required=0 at %0t", $time);
                end else begin
                    proto_exp--;
                end
            end
        end
    end

    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    endtask

    // Full transfer; the expected response is derived from the register model.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wt);
        exp_t        e;
        logic [31:0] word;
        bit          err;
        int          n;
        word     = addr >> 2;
        err      = (addr[1:0] != 2'b00) || (word >= NREGS) || (wr && word == 0);
        e.slverr = err;
        e.waits  = wt;
        e.rdata  = 32'd0;
        if (wr) begin
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model[word[3:0]][8*b +: 8] = data[8*b +: 8];
        end else if (!err) begin
            e.rdata = (word == 0) ? ID : model[word[3:0]];
        end
        exp_q.push_back(e);

        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = data;
        pstrb    = strb;
        cfg_wait = wt;
        pprot    = 3'($urandom);
        @(posedge pclk);
        #1;
        penable  = 1'b1;
        cfg_wait = 4'($urandom);
        n = 0;
        @(negedge pclk);
        while (!pready && n < 40) begin
            n++;
            @(negedge pclk);
        end
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h actual=no_pready required=pready", addr);
        end
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // kind 0: psel dropped mid-wait, kind 1: paddr changed mid-wait, kind 2: penable in idle.
    task automatic abort_xfer(input int kind, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] wt, input int k);
        proto_exp++;
        if (kind == 2) begin
            psel    = 1'b0;
            penable = 1'b1;
            @(posedge pclk);
            #1;
            penable = 1'b0;
        end else begin
            psel     = 1'b1;
            penable  = 1'b0;
            pwrite   = 1'b1;
            paddr    = addr;
            pwdata   = data;
            pstrb    = 4'hF;
            cfg_wait = wt;
            @(posedge pclk);
            #1;
            penable = 1'b1;
            repeat (k) begin
                @(posedge pclk);
                #1;
            end
            if (kind == 0) begin
                psel    = 1'b0;
                penable = 1'b0;
            end else begin
                paddr = addr ^ 32'h4;
            end
            @(posedge pclk);
            #1;
            psel    = 1'b0;
            penable = 1'b0;
        end
        check("proto_err_pulse", {31'd0, proto_err}, 32'd1);
        @(posedge pclk);
        #1;
        check("proto_err_clear", {31'd0, proto_err}, 32'd0);
    endtask

    // Reset asserted k access cycles into a transfer, away from any clock edge.
    task automatic reset_during(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] wt, input int k);
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = data;
        pstrb    = 4'hF;
        cfg_wait = wt;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        repeat (k) begin
            @(posedge pclk);
            #1;
        end
        #2;
        check("pre_reset_pready", {31'd0, pready}, (wt <= k) ? 32'd1 : 32'd0);
        preset_n = 1'b0;
        #1;
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        clear_model();
        @(posedge pclk);
        #1;
        preset_n = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        clear_model();
        preset_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_pready", {31'd0, pready}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        check("reset_pslverr", {31'd0, pslverr}, 32'd0);
        check("reset_proto_err", {31'd0, proto_err}, 32'd0);
        preset_n = 1'b1;
        idle(2);

        // Zero-wait write/read, wait states on the ID register.
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 4'd0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 4'd0);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 4'd3);

        // Byte strobes, ID write protection, out-of-range and misaligned accesses.
        xfer(1'b1, 32'h08, 32'h11223344, 4'hF, 4'd0);
        xfer(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 4'd1);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 4'd0);
        xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 4'd0);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, 4'd2);
        xfer(1'b1, 32'h00, 32'h12345678, 4'hF, 4'd0);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 4'd0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0);
        xfer(1'b1, 32'h06, 32'hCAFEF00D, 4'hF, 4'd2);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, 4'd0);
        idle(1);

        // Protocol violations must leave the target register untouched.
        xfer(1'b1, 32'h0C, 32'h5A5A5A5A, 4'hF, 4'd0);
        abort_xfer(0, 32'h0C, 32'hFFFFFFFF, 4'd5, 2);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, 4'd0);
        abort_xfer(1, 32'h0C, 32'h01010101, 4'd4, 1);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, 4'd1);
        abort_xfer(2, 32'h0, 32'h0, 4'd0, 0);
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, 4'd0);

        // Reset during wait states and during a completing read.
        xfer(1'b1, 32'h10, 32'h13579BDF, 4'hF, 4'd0);
        reset_during(1'b1, 32'h10, 32'h77777777, 4'd6, 2);
        for (int i = 0; i < NREGS; i++) xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, 4'd0);
        xfer(1'b1, 32'h10, 32'h2468ACE0, 4'hF, 4'd1);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0);
        reset_during(1'b0, 32'h00, 32'h0, 4'd0, 0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, 4'd0);

        // Random traffic, mostly back-to-back, with occasional aborts.
        for (int t = 0; t < 300; t++) begin
            a = 32'($urandom_range(0, NREGS * 4 + 15));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) a[31:28] = 4'($urandom_range(1, 15));
            xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            if (t % 50 == 25) begin
                abort_xfer($urandom_range(0, 2), {a[31:2], 2'b00}, $urandom,
                           4'($urandom_range(3, 6)), $urandom_range(0, 2));
            end
        end
        for (int i = 0; i < NREGS; i++) xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, 4'd0);
        idle(3);

        check("pending_responses", exp_q.size(), 32'd0);
        check("pending_proto_err", proto_exp, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
